// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core types and constants (word type, NOP, forwarding selects, MDU states)
package core_pkg;
   typedef logic [31:0] word_t;
   localparam word_t NOP = 32'h0000_0013;
   typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_M = 2'd1, FWD_W = 2'd2} fwd_sel_t;
   typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} mdu_state_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the E operand source for one rs (in: rs_i, M/W rd + regwrite; out: sel_o), M beats W, x0 never matches
module hazard_fwd_sel
   import core_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rd_m_i,
   input  logic       regwrite_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       regwrite_w_i,
   output fwd_sel_t   sel_o
);
   logic hit_m, hit_w;
   assign hit_m = regwrite_m_i && rs_i != 5'd0 && rd_m_i == rs_i;
   assign hit_w = regwrite_w_i && rs_i != 5'd0 && rd_w_i == rs_i;
   assign sel_o = hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush control, E-stage forwarding selects and MUL/DIV occupancy sequencing (in: decoded D/E/M/W fields, redirect, dmem handshake; out: stall_*, flush_*, fwd_a/fwd_b)
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  word_t      instr_d,
   input  word_t      instr_e,
   input  logic [4:0] rd_e,
   input  logic       regwrite_e,
   input  logic       load_e,
   input  logic       mdu_op_e,
   input  logic [4:0] rd_m,
   input  logic       regwrite_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_w,
   input  logic       redirect_e,
   input  logic       dmem_req_m,
   input  logic       dmem_ready,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       stall_m,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic       flush_w,
   output fwd_sel_t   fwd_a,
   output fwd_sel_t   fwd_b
);
   localparam int CW = $clog2(MDU_LAT + 1);
   mdu_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   fwd_sel_t sel_a, sel_b;
   logic [4:0] rs1_d, rs2_d;
   logic load_use, mdu_busy, dmem_wait, redir;
   logic unused_bits;
   assign unused_bits = ^{instr_d[31:25], instr_d[14:0], instr_e[31:25], instr_e[14:0]};
   assign rs1_d = instr_d[19:15];
   assign rs2_d = instr_d[24:20];
   hazard_fwd_sel u_fwd_a (.rs_i(instr_e[19:15]), .rd_m_i(rd_m), .regwrite_m_i(regwrite_m), .rd_w_i(rd_w), .regwrite_w_i(regwrite_w), .sel_o(sel_a));
   hazard_fwd_sel u_fwd_b (.rs_i(instr_e[24:20]), .rd_m_i(rd_m), .regwrite_m_i(regwrite_m), .rd_w_i(rd_w), .regwrite_w_i(regwrite_w), .sel_o(sel_b));
   assign load_use = load_e && regwrite_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
   // The cnt==0 WAIT cycle is the MUL's last E cycle: no stall, and no retrigger while it is still in E.
   assign mdu_busy = state_q == RUN ? (mdu_op_e && MDU_LAT > 1) : cnt_q != '0;
   assign dmem_wait = dmem_req_m && !dmem_ready;
   // E holds the MUL/DIV throughout WAIT, so a redirect then is spurious.
   assign redir = redirect_e && state_q == RUN;
   // Dmem wait freezes F..M, so no flush may destroy a held stage.
   assign stall_f = !rst && (dmem_wait || mdu_busy || (load_use && !redir));
   assign stall_d = stall_f;
   assign stall_e = !rst && (dmem_wait || mdu_busy);
   assign stall_m = !rst && dmem_wait;
   assign flush_d = rst || (!dmem_wait && redir);
   assign flush_e = rst || (!dmem_wait && (redir || load_use));
   assign flush_m = rst || (!dmem_wait && mdu_busy);
   assign flush_w = rst || dmem_wait;
   assign fwd_a = rst ? FWD_RF : sel_a;
   assign fwd_b = rst ? FWD_RF : sel_b;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (rst) begin
         state_d = RUN;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         if (mdu_op_e && MDU_LAT > 1) begin
            state_d = MDU_WAIT;
            cnt_d = CW'(MDU_LAT - 2);
         end
      end else if (cnt_q == '0) begin
         state_d = RUN;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
   end
endmodule
